hazard_flush_ctrl: RTL
======================

Name: hazard_flush_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core.
- Detects load-use hazards between EX and ID, and handles taken-branch/JR redirects.
- Drives PC/IF-ID write enables, the IF/ID squash, and the `flush` input of the ID control-zeroing stage (bubble insertion).
- A small FSM with a down-counter stretches stalls and flushes over configurable multi-cycle penalties; saturating counters record stall and flush cycles.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..7).
- FLUSH_CYCLES, 1, cycles IF/ID is squashed after a redirect (legal 1..7).
- CNT_W, 16, width of performance counters.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high
- EX_MemRead  input  1  instruction in ID/EX is a load
- EX_Rt  input  5  load destination register in ID/EX
- ID_Rs  input  5  rs of instruction in IF/ID
- ID_Rt  input  5  rt of instruction in IF/ID
- ID_UsesRt  input  1  ID instruction reads rt as a source
- branch_taken  input  1  resolved taken branch this cycle
- jr_taken  input  1  JR redirect this cycle
- PCWrite  output  1  PC load enable
- IFIDWrite  output  1  IF/ID register enable
- IFID_flush  output  1  zero IF/ID contents next edge
- flush  output  1  zero ID control signals (bubble into ID/EX)
- busy  output  1  FSM not in IDLE
- stall_count  output  CNT_W  cycles with PCWrite=0 since reset, saturating
- flush_count  output  CNT_W  cycles with IFID_flush=1 since reset, saturating

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high.
- While reset=1: PCWrite=0, IFIDWrite=0, IFID_flush=1, flush=1, busy=0.
  - On the edge: state<=IDLE, cnt<=0, both counters<=0.
- State, cnt (3 bits) and counters are registered. Write-enable/flush outputs are combinational from state and current inputs (Mealy), so a hazard is acted on in the same cycle with zero latency.
- hazard = EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)). Register 0 never causes a stall.
- redirect = branch_taken || jr_taken.
- Default outputs: PCWrite=1, IFIDWrite=1, IFID_flush=0, flush=0.
- IDLE:
  - redirect: IFID_flush=1, flush=1, PCWrite=1.
    - If FLUSH_CYCLES>1: cnt<=FLUSH_CYCLES-1, go FLUSH.
    - Else stay IDLE.
  - else hazard: PCWrite=0, IFIDWrite=0, flush=1.
    - If LOAD_STALL_CYCLES>1: cnt<=LOAD_STALL_CYCLES-1, go STALL.
    - Else stay IDLE.
  - else: defaults.
- STALL:
  - Outputs PCWrite=0, IFIDWrite=0, flush=1.
  - cnt<=cnt-1; when cnt==1, go IDLE.
  - redirect in STALL preempts: behave exactly as IDLE+redirect (outputs and transition). The branch is older than the stalled instruction.
- FLUSH:
  - Outputs IFID_flush=1, flush=1, PCWrite=1, IFIDWrite=1.
  - cnt<=cnt-1; when cnt==1, go IDLE.
  - redirect in FLUSH reloads cnt<=FLUSH_CYCLES-1 and stays FLUSH (when FLUSH_CYCLES>1).
  - hazard ignored in FLUSH, because the ID instruction is squashed.
- Priority: reset > redirect > hazard.
- busy=1 iff state is STALL or FLUSH.
- Counters:
  - stall_count increments each non-reset cycle with PCWrite=0.
  - flush_count increments each non-reset cycle with IFID_flush=1.
  - Both hold at 2^CNT_W-1.
- Reset asserted mid-STALL or mid-FLUSH: next cycle in IDLE with cnt=0, no residual stall.
- Unused state encoding: treated as IDLE on the next edge.

Test Plan:
1. Reset held 3 cycles -> PCWrite=0, IFID_flush=1, flush=1. After release, with no hazard: PCWrite=1, IFIDWrite=1, flush=0, counters=0.
2. Defaults, EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> that cycle PCWrite=0, IFIDWrite=0, flush=1; next cycle defaults; stall_count=1. Repeat with EX_Rt=0 -> no stall. Repeat with ID_Rt=5, ID_UsesRt=0 -> no stall.
3. LOAD_STALL_CYCLES=3, hazard pulsed one cycle -> PCWrite=0 for exactly 3 consecutive cycles, busy=1 in cycles 2-3; stall_count=3.
4. FLUSH_CYCLES=2: branch_taken pulse -> IFID_flush=1 for 2 cycles, PCWrite=1 throughout. jr_taken in 2nd cycle -> IFID_flush extends to 3 cycles total; flush_count=3.
5. LOAD_STALL_CYCLES=3, branch_taken asserted in 2nd stall cycle -> that cycle PCWrite=1, IFID_flush=1; stall ends and no further PCWrite=0 cycles.
6. CNT_W=4, continuous hazard for 20 cycles -> stall_count saturates at 15. Reset mid-STALL -> next cycle busy=0 and counters=0.

Source files
------------

// File: rtl/hazard_flush_ctrl_if.sv
// Hazard/flush handshake between the pipeline datapath (master) and the hazard sequencer (slave).
interface hazard_flush_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             EX_MemRead;
  logic [4:0]       EX_Rt;
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             branch_taken;
  logic             jr_taken;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFID_flush;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, branch_taken, jr_taken,
    input  PCWrite, IFIDWrite, IFID_flush, flush, busy, stall_count, flush_count
  );

  modport slave (
    input  EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, branch_taken, jr_taken,
    output PCWrite, IFIDWrite, IFID_flush, flush, busy, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall and branch/JR flush sequencer for the 5-stage MIPS pipeline.
// Mealy outputs act on a hazard in the same cycle; a down-counter stretches multi-cycle penalties.
module hazard_flush_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_flush_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [2:0] StallLoad  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FlushLoad  = 3'(FLUSH_CYCLES - 1);
  localparam bit         StallMulti = LOAD_STALL_CYCLES > 1;
  localparam bit         FlushMulti = FLUSH_CYCLES > 1;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard, redirect;
  logic pc_write, ifid_write, ifid_flush, id_flush;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign hazard = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                  ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));
  assign redirect = bus.branch_taken || bus.jr_taken;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    id_flush   = 1'b0;
    state_d    = StIdle;
    cnt_d      = 3'd0;

    if (state_q == StFlush) begin
      // The ID instruction is being squashed, so a load-use hazard is irrelevant here.
      ifid_flush = 1'b1;
      id_flush   = 1'b1;
      if (redirect) begin
        cnt_d   = FlushLoad;
        state_d = StFlush;
      end else begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q <= 3'd1) ? StIdle : StFlush;
      end
    end else if (redirect) begin
      // The branch is older than any stalled instruction, so it preempts a stall.
      ifid_flush = 1'b1;
      id_flush   = 1'b1;
      if (FlushMulti) begin
        cnt_d   = FlushLoad;
        state_d = StFlush;
      end
    end else if (state_q == StStall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      id_flush   = 1'b1;
      cnt_d      = cnt_q - 3'd1;
      state_d    = (cnt_q <= 3'd1) ? StIdle : StStall;
    end else if (hazard) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      id_flush   = 1'b1;
      if (StallMulti) begin
        cnt_d   = StallLoad;
        state_d = StStall;
      end
    end

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      id_flush   = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IFIDWrite   = ifid_write;
  assign bus.IFID_flush  = ifid_flush;
  assign bus.flush       = id_flush;
  assign bus.busy        = !reset && ((state_q == StStall) || (state_q == StFlush));
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule
